reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Architectural integer register file (x0..x31, 32-bit) plus a per-register pending-write scoreboard.
- Sits between decode and the write-back stage. The write port is driven directly by write-back outputs: rd_out to wb_rd, write_data to wb_data, reg_we_out to wb_we.
- Decode reads operands here, claims destination registers at issue, and receives a stall when a source or destination has unresolved in-flight writes.

Parameters:
- XLEN, 32, data width of each register.
- PEND_W, 2, width of each per-register in-flight-write counter; max outstanding writes per register = 2^PEND_W - 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rs1_addr  input  5  source 1 register index.
- rs2_addr  input  5  source 2 register index.
- rs1_used  input  1  instruction actually reads rs1.
- rs2_used  input  1  instruction actually reads rs2.
- rs1_data  output  XLEN  source 1 operand, combinational.
- rs2_data  output  XLEN  source 2 operand, combinational.
- issue_valid  input  1  decode presents an instruction for issue this cycle.
- issue_rd  input  5  destination index of the issuing instruction.
- issue_we  input  1  issuing instruction will write issue_rd.
- stall  output  1  combinational; issue not accepted this cycle.
- wb_rd  input  5  write-back destination index.
- wb_data  input  XLEN  write-back data.
- wb_we  input  1  write-back enable.
- err_underflow  output  1  sticky flag; write-back arrived for a register with zero pending count.

Behaviour:
- Reset (rst_n=0 at a rising edge): all 32 registers <= 0, all pending counters <= 0, err_underflow <= 0. During and after reset, rs*_data reads 0 and stall is 0 with no pending state.
- Write:
  - On a rising edge with wb_we=1 and wb_rd!=0, reg[wb_rd] <= wb_data.
  - Writes to x0 are discarded; x0 always reads 0.
- Read is combinational:
  - rsN_data = 0 if rsN_addr==0.
  - Otherwise rsN_data = wb_data if wb_we && wb_rd==rsN_addr (write-through bypass, same cycle).
  - Otherwise rsN_data = reg[rsN_addr].
- Source hazard for rsN (N=1,2) requires all of: rsN_used, rsN_addr!=0, pend[rsN_addr]!=0, and NOT (wb_we && wb_rd==rsN_addr && pend[rsN_addr]==1).
  - In the excluded case, the last outstanding write retires this cycle and the bypass supplies the value.
- Destination hazard: issue_we && issue_rd!=0 && pend[issue_rd]==2^PEND_W-1, unless wb_we && wb_rd==issue_rd retires one this cycle.
- Stall: stall = issue_valid && (src1 hazard || src2 hazard || dest hazard). stall is 0 when issue_valid=0.
- Issue accepted: issue_valid && !stall. An accepted issue with issue_we && issue_rd!=0 claims issue_rd.
- Retire: wb_we && wb_rd!=0.
- Counter update per register r, on the rising edge:
  - claim only: +1.
  - retire only: -1 if pend[r]>0. If pend[r]==0, the counter stays 0 and err_underflow <= 1; the data write still occurs.
  - claim and retire together: unchanged. No error is raised even if pend[r]==0.
  - Counters never wrap; the dest hazard prevents overflow.
- err_underflow stays set until reset.
- Reset mid-operation: all pending claims are discarded. Write-backs arriving after reset for pre-reset claims set err_underflow.
- No latency beyond the edge: a value written at edge k is readable from reg[] after edge k, and via bypass during the cycle before edge k.

Test Plan:
- Reset, then read rs1=5, rs2=0 with issue_valid=1, rs1_used=1 -> rs1_data=0, rs2_data=0, stall=0, err_underflow=0.
- Issue rd=5 (issue_we=1), next cycle issue with rs1_addr=5, rs1_used=1 -> stall=1. Drive wb_we=1, wb_rd=5, wb_data=0x1234_5678 in that cycle -> stall=0, rs1_data=0x12345678 via bypass. Next cycle, without bypass, rs1_data=0x12345678.
- Write wb_rd=0, wb_data=0xFFFF_FFFF, wb_we=1; issue rd=0; read rs1=0 -> rs1_data=0, no stall, pend[0] stays 0.
- Issue rd=7 three times (PEND_W=2) -> fourth issue rd=7 gives stall=1. Same cycle wb_rd=7 -> stall=0 and the count stays 3. Three further write-backs -> a read of x7 with rs1_used=1 gives stall=0.
- With pend[9]=0, drive wb_we=1, wb_rd=9, wb_data=0xA5 -> reg9=0xA5, err_underflow=1 and it stays 1. Assert rst_n=0 for one edge -> err_underflow=0 and reg9 reads 0.
- Issue rd=3, then rst_n=0 for one edge, then read rs1=3 with rs1_used=1 -> stall=0 (claims cleared).

Source files
------------

// File: rtl/reg_file_scoreboard_if.sv
// Decode/write-back bus of the integer register file with its pending-write scoreboard.
// master drives operand reads, issue claims and write-backs; slave is the register file.
interface reg_file_scoreboard_if #(
    parameter int unsigned XLEN = 32
);
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_we;
    logic            stall;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            err_underflow;

    modport master (
        output rs1_addr, rs2_addr, rs1_used, rs2_used,
        output issue_valid, issue_rd, issue_we,
        output wb_rd, wb_data, wb_we,
        input  rs1_data, rs2_data, stall, err_underflow
    );

    modport slave (
        input  rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  issue_valid, issue_rd, issue_we,
        input  wb_rd, wb_data, wb_we,
        output rs1_data, rs2_data, stall, err_underflow
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// x0..x31 register file with write-through bypass and per-register in-flight-write counters
// that stall decode on RAW hazards or when a destination's counter is saturated.
module reg_file_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PEND_W = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    reg_file_scoreboard_if.slave bus
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [XLEN-1:0]   regs_q [32];
    logic [XLEN-1:0]   regs_d [32];
    logic [PEND_W-1:0] pend_q [32];
    logic [PEND_W-1:0] pend_d [32];
    logic              err_q;
    logic              err_d;

    logic src1_haz;
    logic src2_haz;
    logic dest_haz;
    logic claim;
    logic retire;

    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr != 5'd0) begin
            if (bus.wb_we && bus.wb_rd == bus.rs1_addr) bus.rs1_data = bus.wb_data;
            else                                        bus.rs1_data = regs_q[bus.rs1_addr];
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr != 5'd0) begin
            if (bus.wb_we && bus.wb_rd == bus.rs2_addr) bus.rs2_data = bus.wb_data;
            else                                        bus.rs2_data = regs_q[bus.rs2_addr];
        end
    end

    // A source whose last outstanding write retires this cycle is served by the bypass.
    always_comb begin
        src1_haz = bus.rs1_used && (bus.rs1_addr != 5'd0) && (pend_q[bus.rs1_addr] != '0) &&
                   !(bus.wb_we && bus.wb_rd == bus.rs1_addr && pend_q[bus.rs1_addr] == PEND_ONE);
        src2_haz = bus.rs2_used && (bus.rs2_addr != 5'd0) && (pend_q[bus.rs2_addr] != '0) &&
                   !(bus.wb_we && bus.wb_rd == bus.rs2_addr && pend_q[bus.rs2_addr] == PEND_ONE);
        dest_haz = bus.issue_we && (bus.issue_rd != 5'd0) && (pend_q[bus.issue_rd] == PEND_MAX) &&
                   !(bus.wb_we && bus.wb_rd == bus.issue_rd);
        bus.stall = bus.issue_valid && (src1_haz || src2_haz || dest_haz);
        claim     = bus.issue_valid && !bus.stall && bus.issue_we && (bus.issue_rd != 5'd0);
        retire    = bus.wb_we && (bus.wb_rd != 5'd0);
    end

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q;
        if (retire) regs_d[bus.wb_rd] = bus.wb_data;
        // Claim and retire of the same register cancel, even from a zero count.
        if (!(claim && retire && bus.issue_rd == bus.wb_rd)) begin
            if (claim) pend_d[bus.issue_rd] = pend_q[bus.issue_rd] + PEND_ONE;
            if (retire) begin
                if (pend_q[bus.wb_rd] != '0) pend_d[bus.wb_rd] = pend_q[bus.wb_rd] - PEND_ONE;
                else                         err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            pend_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: reset, bypass, x0, counter saturation, underflow.
module tb_reg_file_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    reg_file_scoreboard_if #(.XLEN(32)) bus ();

    reg_file_scoreboard #(.XLEN(32), .PEND_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.rs1_addr = '0; bus.rs2_addr = '0; bus.rs1_used = 1'b0; bus.rs2_used = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_we = 1'b0;
        bus.wb_rd = '0; bus.wb_data = '0; bus.wb_we = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        bus.rs1_addr = 5'd5; bus.rs1_used = 1'b1; bus.issue_valid = 1'b1;
        step(); step();
        #2;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL reset_in_rs1 got=%h exp=0", bus.rs1_data); else passed++;
        total++; if (bus.stall !== 1'b0) $display("FAIL reset_in_stall got=%b exp=0", bus.stall); else passed++;
        rst_n = 1'b1;
        step();
        #2;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL reset_rs1 got=%h exp=0", bus.rs1_data); else passed++;
        total++; if (bus.rs2_data !== 32'h0) $display("FAIL reset_rs2 got=%h exp=0", bus.rs2_data); else passed++;
        total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err_underflow); else passed++;
        step();
    endtask

    task automatic test_bypass();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_we = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b0) $display("FAIL byp_claim_stall got=%b exp=0", bus.stall); else passed++;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd5; bus.rs1_used = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b1) $display("FAIL byp_raw_stall got=%b exp=1", bus.stall); else passed++;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234_5678;
        #2;
        total++; if (bus.stall !== 1'b0) $display("FAIL byp_retire_stall got=%b exp=0", bus.stall); else passed++;
        total++; if (bus.rs1_data !== 32'h1234_5678) $display("FAIL byp_data got=%h exp=12345678", bus.rs1_data); else passed++;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd5; bus.rs1_used = 1'b1;
        bus.rs2_addr = 5'd5; bus.rs2_used = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b0) $display("FAIL byp_after_stall got=%b exp=0", bus.stall); else passed++;
        total++; if (bus.rs1_data !== 32'h1234_5678) $display("FAIL reg_rs1 got=%h exp=12345678", bus.rs1_data); else passed++;
        total++; if (bus.rs2_data !== 32'h1234_5678) $display("FAIL reg_rs2 got=%h exp=12345678", bus.rs2_data); else passed++;
        step();
    endtask

    task automatic test_x0();
        idle();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.issue_we = 1'b1;
        bus.rs1_addr = 5'd0; bus.rs1_used = 1'b1;
        #2;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL x0_bypass got=%h exp=0", bus.rs1_data); else passed++;
        total++; if (bus.stall !== 1'b0) $display("FAIL x0_stall got=%b exp=0", bus.stall); else passed++;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd0; bus.rs1_used = 1'b1;
        #2;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL x0_read got=%h exp=0", bus.rs1_data); else passed++;
        total++; if (bus.stall !== 1'b0) $display("FAIL x0_read_stall got=%b exp=0", bus.stall); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL x0_err got=%b exp=0", bus.err_underflow); else passed++;
        step();
    endtask

    task automatic test_dest_full();
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_we = 1'b1;
            #2;
            total++; if (bus.stall !== 1'b0) $display("FAIL full_claim%0d got=%b exp=0", i, bus.stall); else passed++;
            step();
        end
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_we = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b1) $display("FAIL full_stall got=%b exp=1", bus.stall); else passed++;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h0000_0071;
        #2;
        total++; if (bus.stall !== 1'b0) $display("FAIL full_retire_ok got=%b exp=0", bus.stall); else passed++;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_we = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b1) $display("FAIL full_still3 got=%b exp=1", bus.stall); else passed++;
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h0000_0072 + 32'(i);
            bus.issue_valid = 1'b1; bus.rs1_addr = 5'd7; bus.rs1_used = 1'b1;
            #2;
            if (i == 2) begin
                total++; if (bus.stall !== 1'b0) $display("FAIL full_last_retire got=%b exp=0", bus.stall); else passed++;
            end else begin
                total++; if (bus.stall !== 1'b1) $display("FAIL full_retire%0d got=%b exp=1", i, bus.stall); else passed++;
            end
            step();
        end
        idle();
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd7; bus.rs1_used = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b0) $display("FAIL full_drained got=%b exp=0", bus.stall); else passed++;
        total++; if (bus.rs1_data !== 32'h0000_0074) $display("FAIL full_data got=%h exp=00000074", bus.rs1_data); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL full_err got=%b exp=0", bus.err_underflow); else passed++;
        step();
    endtask

    task automatic test_claim_retire();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12; bus.issue_we = 1'b1;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd12; bus.wb_data = 32'hC0DE_0012;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd12; bus.rs1_used = 1'b1;
        #2;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL cr_err got=%b exp=0", bus.err_underflow); else passed++;
        total++; if (bus.stall !== 1'b0) $display("FAIL cr_stall got=%b exp=0", bus.stall); else passed++;
        total++; if (bus.rs1_data !== 32'hC0DE_0012) $display("FAIL cr_data got=%h exp=c0de0012", bus.rs1_data); else passed++;
        step();
    endtask

    task automatic test_underflow();
        idle();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h0000_00A5;
        step();
        idle();
        bus.rs2_addr = 5'd9;
        #2;
        total++; if (bus.rs2_data !== 32'h0000_00A5) $display("FAIL uf_data got=%h exp=000000a5", bus.rs2_data); else passed++;
        total++; if (bus.err_underflow !== 1'b1) $display("FAIL uf_set got=%b exp=1", bus.err_underflow); else passed++;
        step(); step();
        #2;
        total++; if (bus.err_underflow !== 1'b1) $display("FAIL uf_sticky got=%b exp=1", bus.err_underflow); else passed++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.rs2_addr = 5'd9;
        #2;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL uf_clear got=%b exp=0", bus.err_underflow); else passed++;
        total++; if (bus.rs2_data !== 32'h0) $display("FAIL uf_reg_clear got=%h exp=0", bus.rs2_data); else passed++;
        step();
    endtask

    task automatic test_reset_claims();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.issue_we = 1'b1;
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd3; bus.rs1_used = 1'b1;
        #2;
        total++; if (bus.stall !== 1'b0) $display("FAIL rc_stall got=%b exp=0", bus.stall); else passed++;
        step();
        idle();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_0033;
        step();
        idle();
        #2;
        total++; if (bus.err_underflow !== 1'b1) $display("FAIL rc_late_wb_err got=%b exp=1", bus.err_underflow); else passed++;
        step();
    endtask

    initial begin
        idle();
        step();
        test_reset();
        test_bypass();
        test_x0();
        test_dest_full();
        test_claim_retire();
        test_underflow();
        test_reset_claims();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
